// File: rtl/simon_decifra_if.sv
// Request/response bus for the Simon 128/128 decryption block.
// The requester drives ciphertext and key; the decryptor returns plaintext.
interface simon_decifra_if;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] ct_i;
  logic [127:0] k0_i;
  logic         key_reuse_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] pt_o;

  modport master (
    output in_valid_i, ct_i, k0_i, key_reuse_i, out_ready_i,
    input  in_ready_o, out_valid_o, pt_o
  );

  modport slave (
    input  in_valid_i, ct_i, k0_i, key_reuse_i, out_ready_i,
    output in_ready_o, out_valid_o, pt_o
  );
endinterface

// File: rtl/simon_decifra.sv
// Iterative Simon 128/128 decryption: one key-expansion step or one round per cycle.
// Round keys persist in a 68-entry table so later requests can skip key expansion.
module simon_decifra (
  input  logic           clk,
  input  logic           rst_n,
  simon_decifra_if.slave bus
);

  localparam int unsigned W      = 64;
  localparam int unsigned NKEYS  = 68;
  localparam int unsigned IDX_W  = 7;
  localparam logic [61:0] Z2     = 62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

  state_t           state;
  logic [W-1:0]     x, y;
  logic [W-1:0]     kp1, kp2;
  logic [IDX_W-1:0] idx, rnd;
  logic             tbl_valid;
  logic             in_ready, out_valid;
  logic [127:0]     pt;
  logic [W-1:0]     tbl [NKEYS];

  logic             accept_c, fresh_c;
  logic [5:0]       zsel_c;
  logic [W-1:0]     t_c, knext_c, rk_c, f_c, y_nxt_c;

  // Key-schedule step and decryption round datapath.
  always_comb begin
    accept_c = (state == IDLE) && bus.in_valid_i;
    fresh_c  = accept_c && !(bus.key_reuse_i && tbl_valid);
    zsel_c   = (idx >= IDX_W'(64)) ? 6'(idx - IDX_W'(64)) : 6'(idx - IDX_W'(2));
    t_c      = {kp1[2:0], kp1[W-1:3]};
    knext_c  = ~kp2 ^ t_c ^ {t_c[0], t_c[W-1:1]} ^ {63'd0, Z2[6'd61 - zsel_c]} ^ 64'h3;
    rk_c     = tbl[rnd];
    f_c      = ({y[W-2:0], y[W-1]} & {y[W-9:0], y[W-1:W-8]}) ^ {y[W-3:0], y[W-1:W-2]};
    y_nxt_c  = x ^ f_c ^ rk_c;
  end

  // Round-key storage; not reset, validity is tracked separately.
  always_ff @(posedge clk) begin
    if (fresh_c) begin
      tbl[0] <= bus.k0_i[63:0];
      tbl[1] <= bus.k0_i[127:64];
    end else if (state == KEXP) begin
      tbl[idx] <= knext_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      kp1       <= '0;
      kp2       <= '0;
      idx       <= '0;
      rnd       <= '0;
      tbl_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      pt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            x        <= bus.ct_i[127:64];
            y        <= bus.ct_i[63:0];
            in_ready <= 1'b0;
            if (fresh_c) begin
              kp2       <= bus.k0_i[63:0];
              kp1       <= bus.k0_i[127:64];
              idx       <= IDX_W'(2);
              tbl_valid <= 1'b0;
              state     <= KEXP;
            end else begin
              rnd   <= IDX_W'(NKEYS - 1);
              state <= DEC;
            end
          end
        end
        KEXP: begin
          kp2 <= kp1;
          kp1 <= knext_c;
          idx <= idx + IDX_W'(1);
          if (idx == IDX_W'(NKEYS - 1)) begin
            rnd       <= IDX_W'(NKEYS - 1);
            tbl_valid <= 1'b1;
            state     <= DEC;
          end
        end
        DEC: begin
          x <= y;
          y <= y_nxt_c;
          if (rnd == '0) begin
            pt        <= {y, y_nxt_c};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rnd <= rnd - IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.pt_o        = pt;

endmodule

// File: tb/tb_simon_decifra.sv
// Directed bench for simon_decifra: known answer, key reuse, backpressure,
// reset abort, ignored inputs while busy, and encrypt/decrypt round trips.
module tb_simon_decifra;

  localparam logic [127:0] KAT_K = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KAT_C = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
  localparam logic [127:0] KAT_P = 128'h6373656420737265_6c6c657661727420;
  localparam logic [63:0]  Z2_HEX = 64'h3369F885192C0EF5;
  localparam int           TMO    = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] mk [68];

  always #5 clk = ~clk;

  simon_decifra_if bus ();

  simon_decifra dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [63:0] rotl(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [63:0] t;
    logic [63:0] zb;
    mk[0] = k[63:0];
    mk[1] = k[127:64];
    for (int i = 2; i < 68; i++) begin
      t  = rotr(mk[i-1], 3);
      t  = t ^ rotr(t, 1);
      zb = (Z2_HEX >> ((i - 2) % 62)) & 64'd1;
      mk[i] = ~mk[i-2] ^ t ^ zb ^ 64'd3;
    end
  endtask

  function automatic logic [127:0] simon_enc(input logic [127:0] p);
    logic [63:0] a, b, tmp;
    a = p[127:64];
    b = p[63:0];
    for (int i = 0; i < 68; i++) begin
      tmp = a;
      a   = b ^ ((rotl(a, 1) & rotl(a, 8)) ^ rotl(a, 2)) ^ mk[i];
      b   = tmp;
    end
    return {a, b};
  endfunction

  task automatic start_req(input logic [127:0] ct, input logic [127:0] k, input logic reuse);
    @(negedge clk);
    bus.in_valid_i  = 1'b1;
    bus.ct_i        = ct;
    bus.k0_i        = k;
    bus.key_reuse_i = reuse;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input logic toggle, output int lat);
    lat = 0;
    while (bus.out_valid_o !== 1'b1 && lat < TMO) begin
      @(posedge clk);
      #1;
      lat++;
      if (toggle && bus.out_valid_o !== 1'b1) begin
        bus.in_valid_i  = 1'($urandom_range(0, 1));
        bus.key_reuse_i = 1'($urandom_range(0, 1));
        bus.ct_i        = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic release_out;
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.pt_o !== 128'd0) begin
      errors++;
      $display("FAIL reset_async: out_valid=%b pt=%h, want 0/0", bus.out_valid_o, bus.pt_o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.pt_o !== 128'd0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b pt=%h, want 1/0/0",
               bus.in_ready_o, bus.out_valid_o, bus.pt_o);
    end
  endtask

  task automatic test_kat_fresh;
    int lat;
    start_req(KAT_C, KAT_K, 1'b0);
    checks++;
    if (bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL kat_busy_ready: in_ready=%b, want 0", bus.in_ready_o);
    end
    wait_done(1'b0, lat);
    checks++;
    if (lat !== 134) begin
      errors++;
      $display("FAIL kat_fresh_latency: got %0d, want 134", lat);
    end
    checks++;
    if (bus.pt_o !== KAT_P) begin
      errors++;
      $display("FAIL kat_fresh_pt: got %h, want %h", bus.pt_o, KAT_P);
    end
    release_out();
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kat_fresh_release: in_ready=%b out_valid=%b, want 1/0",
               bus.in_ready_o, bus.out_valid_o);
    end
  endtask

  task automatic test_kat_reuse;
    int lat;
    start_req(KAT_C, 128'd0, 1'b1);
    wait_done(1'b0, lat);
    checks++;
    if (lat !== 68) begin
      errors++;
      $display("FAIL kat_reuse_latency: got %0d, want 68", lat);
    end
    checks++;
    if (bus.pt_o !== KAT_P) begin
      errors++;
      $display("FAIL kat_reuse_pt: got %h, want %h", bus.pt_o, KAT_P);
    end
    release_out();
  endtask

  task automatic test_backpressure;
    int lat;
    start_req(KAT_C, 128'd0, 1'b1);
    wait_done(1'b0, lat);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.pt_o !== KAT_P) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b pt=%h, want 1/0/%h",
                 c, bus.out_valid_o, bus.in_ready_o, bus.pt_o, KAT_P);
      end
    end
    release_out();
    checks++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1/0",
               bus.in_ready_o, bus.out_valid_o);
    end
  endtask

  task automatic test_reset_mid_dec;
    int lat;
    start_req(KAT_C, 128'd0, 1'b1);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_dec: out_valid=%b in_ready=%b, want 0/1",
               bus.out_valid_o, bus.in_ready_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_req(KAT_C, KAT_K, 1'b1);
    wait_done(1'b0, lat);
    checks++;
    if (lat !== 134) begin
      errors++;
      $display("FAIL after_reset_latency: got %0d, want 134", lat);
    end
    checks++;
    if (bus.pt_o !== KAT_P) begin
      errors++;
      $display("FAIL after_reset_pt: got %h, want %h", bus.pt_o, KAT_P);
    end
    release_out();
  endtask

  task automatic test_in_valid_toggle;
    int lat;
    start_req(KAT_C, KAT_K, 1'b0);
    wait_done(1'b1, lat);
    checks++;
    if (lat !== 134) begin
      errors++;
      $display("FAIL toggle_latency: got %0d, want 134", lat);
    end
    checks++;
    if (bus.pt_o !== KAT_P) begin
      errors++;
      $display("FAIL toggle_pt: got %h, want %h", bus.pt_o, KAT_P);
    end
    release_out();
  endtask

  task automatic test_round_trip;
    logic [127:0] key, p, c;
    logic         reuse;
    int           lat, want_lat;
    key = '0;
    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 0) begin
        key = {$urandom, $urandom, $urandom, $urandom};
        expand(key);
        reuse    = 1'b0;
        want_lat = 134;
      end else begin
        reuse    = 1'b1;
        want_lat = 68;
      end
      p = {$urandom, $urandom, $urandom, $urandom};
      c = simon_enc(p);
      start_req(c, reuse ? {$urandom, $urandom, $urandom, $urandom} : key, reuse);
      wait_done(1'b0, lat);
      checks++;
      if (lat !== want_lat || bus.pt_o !== p) begin
        errors++;
        $display("FAIL round_trip %0d: pt=%h lat=%0d, want %h lat=%0d",
                 i, bus.pt_o, lat, p, want_lat);
      end
      release_out();
    end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.ct_i        = '0;
    bus.k0_i        = '0;
    bus.key_reuse_i = 1'b0;
    bus.out_ready_i = 1'b0;
    test_reset();
    test_kat_fresh();
    test_kat_reuse();
    test_backpressure();
    test_reset_mid_dec();
    test_in_valid_toggle();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
